// File: rtl/issue_stage_pkg.sv
// Shared micro-op types for the issue stage: decoded uop, issued uop with operands,
// and the register-value selection used for operand read with writeback bypass.
package issue_stage_pkg;

  typedef logic [4:0]  reg_t;
  typedef logic [31:0] val_t;

  typedef enum logic [2:0] {
    OpAdd, OpSub, OpAnd, OpOr, OpXor, OpLoad, OpStore
  } op_t;

  typedef enum logic [1:0] {
    ExNone, ExIllegal, ExFetchFault
  } ex_t;

  typedef struct packed {
    op_t  op;
    ex_t  ex;
    reg_t rd;
    reg_t rs1;
    reg_t rs2;
    logic imm_valid;
    val_t imm;
  } dec_t;

  typedef struct packed {
    dec_t dec;
    val_t op_a;
    val_t op_b;
    val_t st_data;
  } issue_t;

  // r0 is hardwired to zero; a same-cycle writeback overrides the regfile read.
  function automatic val_t reg_value(input reg_t r, input val_t rdata, input logic bypass,
                                     input logic wb_valid, input reg_t wb_rd,
                                     input val_t wb_data);
    if (r == '0) return '0;
    if (bypass && wb_valid && (wb_rd == r)) return wb_data;
    return rdata;
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Busy-bit scoreboard for pending destination writes. Set wins over clear on the
// same register; lookups see a same-cycle writeback as already complete when bypassing.
module issue_scoreboard
  import issue_stage_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 32,
  parameter bit          BYPASS_WB  = 1'b1,
  parameter int unsigned NUM_LOOKUP = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_i,
  input  reg_t                  set_rd_i,
  input  logic                  clr_i,
  input  reg_t                  clr_rd_i,
  input  reg_t [NUM_LOOKUP-1:0] lookup_i,
  output logic [NUM_LOOKUP-1:0] busy_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_i && (clr_rd_i != '0)) busy_d[clr_rd_i] = 1'b0;
    if (set_i && (set_rd_i != '0)) busy_d[set_rd_i] = 1'b1;
  end

  always_comb begin
    busy_o = '0;
    for (int i = 0; i < NUM_LOOKUP; i++) begin
      busy_o[i] = (lookup_i[i] != '0) && busy_q[lookup_i[i]] &&
                  !(BYPASS_WB && clr_i && (clr_rd_i == lookup_i[i]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

endmodule

// File: rtl/issue_stage.sv
// In-order issue stage: holds one accepted uop (S), waits for its operands to be
// free, then moves it with its read operands into the issue register (O).
module issue_stage
  import issue_stage_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 32,
  parameter bit          BYPASS_WB = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  output logic   in_ready,
  input  dec_t   in_uop,
  output reg_t   rf_raddr1,
  input  val_t   rf_rdata1,
  output reg_t   rf_raddr2,
  input  val_t   rf_rdata2,
  input  logic   wb_valid,
  input  reg_t   wb_rd,
  input  val_t   wb_data,
  input  logic   flush,
  output logic   out_valid,
  input  logic   out_ready,
  output issue_t out_issue
);

  logic   s_valid_q, s_valid_d;
  dec_t   s_uop_q, s_uop_d;
  logic   o_valid_q, o_valid_d;
  issue_t o_q, o_d;

  logic       no_ex;
  logic       hazard;
  logic       xfer;
  logic [2:0] lk_busy;
  val_t       val1, val2;

  assign no_ex = (s_uop_q.ex == ExNone);

  issue_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .BYPASS_WB (BYPASS_WB),
    .NUM_LOOKUP(3)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_i   (xfer && no_ex),
    .set_rd_i(s_uop_q.rd),
    .clr_i   (wb_valid),
    .clr_rd_i(wb_rd),
    .lookup_i({s_uop_q.rd, s_uop_q.rs2, s_uop_q.rs1}),
    .busy_o  (lk_busy)
  );

  // Exception uops carry no real operands, so they never wait on registers.
  assign hazard   = no_ex && (|lk_busy);
  assign xfer     = s_valid_q && !hazard && (!o_valid_q || out_ready) && !flush;
  assign in_ready = !s_valid_q || xfer;

  assign rf_raddr1 = s_uop_q.rs1;
  assign rf_raddr2 = s_uop_q.rs2;
  assign val1 = reg_value(s_uop_q.rs1, rf_rdata1, BYPASS_WB, wb_valid, wb_rd, wb_data);
  assign val2 = reg_value(s_uop_q.rs2, rf_rdata2, BYPASS_WB, wb_valid, wb_rd, wb_data);

  always_comb begin
    s_valid_d = s_valid_q;
    s_uop_d   = s_uop_q;
    if (xfer) s_valid_d = 1'b0;
    if (in_valid && in_ready) begin
      s_valid_d = 1'b1;
      s_uop_d   = in_uop;
    end
    if (flush) s_valid_d = 1'b0;
  end

  always_comb begin
    o_valid_d = o_valid_q;
    o_d       = o_q;
    if (xfer) begin
      o_valid_d = 1'b1;
      o_d.dec   = s_uop_q;
      if (no_ex) begin
        o_d.op_a    = val1;
        o_d.op_b    = s_uop_q.imm_valid ? s_uop_q.imm : val2;
        o_d.st_data = val2;
      end else begin
        o_d.op_a    = '0;
        o_d.op_b    = '0;
        o_d.st_data = '0;
      end
    end else if (out_ready) begin
      o_valid_d = 1'b0;
      o_d       = '0;
    end
    if (flush) o_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid_q <= 1'b0;
      s_uop_q   <= '0;
      o_valid_q <= 1'b0;
      o_q       <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      s_uop_q   <= s_uop_d;
      o_valid_q <= o_valid_d;
      o_q       <= o_d;
    end
  end

  assign out_valid = o_valid_q;
  assign out_issue = o_q;

endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage: stimulus pushes expected issues into a queue,
// an independent monitor pops and compares on every output handshake.
module tb_issue_stage;
  import issue_stage_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   in_valid = 1'b0;
  logic   in_ready;
  dec_t   in_uop = '0;
  reg_t   rf_raddr1, rf_raddr2;
  val_t   rf_rdata1, rf_rdata2;
  logic   wb_valid = 1'b0;
  reg_t   wb_rd = '0;
  val_t   wb_data = '0;
  logic   flush = 1'b0;
  logic   out_valid;
  logic   out_ready = 1'b1;
  issue_t out_issue;

  val_t   rf [32];
  issue_t exp_q[$];
  issue_t mon_exp;
  int     checks = 0;
  int     failures = 0;

  always #5 clk = ~clk;

  issue_stage dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_uop   (in_uop),
    .rf_raddr1(rf_raddr1),
    .rf_rdata1(rf_rdata1),
    .rf_raddr2(rf_raddr2),
    .rf_rdata2(rf_rdata2),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_issue(out_issue)
  );

  // Register file model; r0 holds junk so a missing r0 override shows up.
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];
  always @(posedge clk) if (wb_valid && wb_rd != '0) rf[wb_rd] <= wb_data;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic dec_t mk(input op_t op, input reg_t rd, input reg_t rs1, input reg_t rs2,
                              input logic immv, input val_t imm, input ex_t ex);
    dec_t d;
    d.op = op; d.ex = ex; d.rd = rd; d.rs1 = rs1; d.rs2 = rs2;
    d.imm_valid = immv; d.imm = imm;
    return d;
  endfunction

  function automatic issue_t ie(input dec_t d, input val_t a, input val_t b, input val_t s);
    issue_t r;
    r.dec = d; r.op_a = a; r.op_b = b; r.st_data = s;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_unexpected: got %0h expected none", out_issue);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_issue", out_issue, mon_exp);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input dec_t u, input issue_t e);
    int n = 0;
    in_valid = 1'b1;
    in_uop   = u;
    exp_q.push_back(e);
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wb(input reg_t r, input val_t d);
    wb_valid = 1'b1; wb_rd = r; wb_data = d;
    cyc(1);
    wb_valid = 1'b0;
  endtask

  dec_t u_a, u_b, u_c, u_x;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    rf[0] = 32'hDEAD_BEEF;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    cyc(2);
    rst = 1'b0;
    cyc(1);

    // 1: reset with S and O both occupied
    out_ready = 1'b0;
    send(mk(OpAdd, 5'd5, 5'd1, 5'd2, 1'b0, 0, ExNone), '0);
    send(mk(OpAdd, 5'd6, 5'd2, 5'd1, 1'b0, 0, ExNone), '0);
    rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", dut.u_scoreboard.busy_q, 0);
    check("rst_out_issue", out_issue, 0);
    exp_q.delete();
    cyc(1);
    rst = 1'b0;
    out_ready = 1'b1;

    // 2/3: ADD r3 then dependent ADDI r4 resolved by bypass
    u_a = mk(OpAdd, 5'd3, 5'd1, 5'd2, 1'b0, 0, ExNone);
    send(u_a, ie(u_a, 5, 7, 7));
    u_b = mk(OpAdd, 5'd4, 5'd3, 5'd0, 1'b1, 1, ExNone);
    send(u_b, ie(u_b, 12, 1, 0));
    check("busy_r3", dut.u_scoreboard.busy_q[3], 1);
    @(negedge clk);
    check("stall_in_ready", in_ready, 0);
    cyc(2);
    @(negedge clk);
    check("stall_no_issue", out_valid, 0);
    check("stall_in_ready2", in_ready, 0);
    @(posedge clk); #1;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'd12;
    @(posedge clk); #1;
    wb_valid = 1'b0;
    @(negedge clk);
    check("bypass_timing", out_valid, 1);
    cyc(1);
    wb(5'd4, 32'd13);
    check("busy_clear", dut.u_scoreboard.busy_q, 0);

    // 4: store word r2 -> [r1+8]
    u_a = mk(OpStore, 5'd0, 5'd1, 5'd2, 1'b1, 8, ExNone);
    send(u_a, ie(u_a, 5, 8, 7));
    cyc(3);
    check("store_no_busy", dut.u_scoreboard.busy_q, 0);

    // 5: back-pressure with O and S full, then ordered drain
    out_ready = 1'b0;
    u_a = mk(OpAdd, 5'd7, 5'd1, 5'd2, 1'b0, 0, ExNone);
    u_b = mk(OpSub, 5'd8, 5'd2, 5'd0, 1'b0, 0, ExNone);
    u_c = mk(OpAnd, 5'd9, 5'd0, 5'd2, 1'b1, 32'h55, ExNone);
    send(u_a, ie(u_a, 5, 7, 7));
    send(u_b, ie(u_b, 7, 0, 0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_out_issue", out_issue, ie(u_a, 5, 7, 7));
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(u_c, ie(u_c, 0, 32'h55, 7));
    cyc(4);
    check("drain_empty", exp_q.size(), 0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;

    // 6: exception uop behind a hazard, then flush with S and O full
    u_a = mk(OpAdd, 5'd10, 5'd1, 5'd2, 1'b0, 0, ExNone);
    send(u_a, ie(u_a, 5, 7, 7));
    u_b = mk(OpAdd, 5'd11, 5'd10, 5'd1, 1'b0, 0, ExNone);
    send(u_b, ie(u_b, 100, 5, 5));
    u_x = mk(OpAdd, 5'd12, 5'd11, 5'd2, 1'b1, 9, ExIllegal);
    fork
      send(u_x, ie(u_x, 0, 0, 0));
      begin
        cyc(3);
        wb(5'd10, 32'd100);
      end
    join
    cyc(3);
    check("exc_busy", dut.u_scoreboard.busy_q, 32'h0000_0800);
    check("exc_drained", exp_q.size(), 0);

    out_ready = 1'b0;
    u_a = mk(OpAdd, 5'd13, 5'd1, 5'd2, 1'b0, 0, ExNone);
    u_b = mk(OpAdd, 5'd14, 5'd2, 5'd1, 1'b0, 0, ExNone);
    send(u_a, ie(u_a, 5, 7, 7));
    send(u_b, ie(u_b, 7, 5, 5));
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    #1;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_busy", dut.u_scoreboard.busy_q, 32'h0000_2800);
    exp_q.delete();
    out_ready = 1'b1;
    u_c = mk(OpSub, 5'd0, 5'd2, 5'd1, 1'b0, 0, ExNone);
    send(u_c, ie(u_c, 7, 5, 5));
    cyc(4);
    check("final_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
